// File: rtl/rt_pixel_scanner.sv
// ---------------------------------------------------------------------------
// rt_pixel_scanner
//
// Frame-level sequencer that sits directly upstream of the ray generation
// unit (RGU). A frame_start pulse walks every pixel of an IMG_W x IMG_H image
// in raster order (y outer, x inner). For each pixel the scanner:
//   1. drives the fixed-point pixel coordinate (integer << FP_QW) and a
//      one-cycle start pulse to the RGU,
//   2. waits for the RGU result and captures it together with the integer
//      pixel coordinate,
//   3. presents the ray on a valid/ready interface until it is accepted.
// Only one pixel is in flight at a time. The next pixel is issued only after
// the current ray has been accepted downstream.
//
// Parameters
//   IMG_W, IMG_H  image size in pixels (>= 1)
//   CW            integer pixel counter width, 2**CW > max(IMG_W, IMG_H)
//   FP_WL         fixed-point word length (>= CW)
//   FP_QW         fixed-point fractional bits
//
// Ports
//   clk           system clock
//   reset         asynchronous active-high reset; abandons any frame in progress
//   frame_start   one-cycle request to render a frame (ignored unless idle)
//   frame_busy    high from the cycle after an accepted frame_start until the
//                 cycle after frame_done
//   frame_done    one-cycle pulse after the last ray has been accepted
//   rgu_start     one-cycle start strobe to the RGU
//   rgu_x, rgu_y  pixel coordinate in fixed point, stable while the RGU works
//   rgu_valid     RGU result strobe (only honoured while waiting for a result)
//   rgu_origin    RGU ray origin, three packed FP_WL words
//   rgu_dir       RGU ray direction, three packed FP_WL words
//   out_valid     output ray valid
//   out_ready     downstream ready; transfer on out_valid & out_ready
//   out_px/out_py integer pixel coordinate of the output ray
//   out_last      output ray is the final pixel (IMG_W-1, IMG_H-1)
//   out_origin    registered ray origin
//   out_dir       registered ray direction
//
// Optional feature (macro RT_SCAN_PERF_EN)
//   perf_cycles   32-bit count of cycles with frame_busy high. Cleared on an
//                 accepted frame_start, holds after frame_done, saturates.
// ---------------------------------------------------------------------------
module rt_pixel_scanner #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int CW    = 16,
  parameter int FP_WL = 32,
  parameter int FP_QW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 rgu_start,
  output logic [FP_WL-1:0]     rgu_x,
  output logic [FP_WL-1:0]     rgu_y,
  input  logic                 rgu_valid,
  input  logic [3*FP_WL-1:0]   rgu_origin,
  input  logic [3*FP_WL-1:0]   rgu_dir,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_px,
  output logic [CW-1:0]        out_py,
  output logic                 out_last,
  output logic [3*FP_WL-1:0]   out_origin,
  output logic [3*FP_WL-1:0]   out_dir
`ifdef RT_SCAN_PERF_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST_X = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_Y = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t          state;
  logic [CW-1:0]   px;
  logic [CW-1:0]   py;
  logic [CW-1:0]   nx_px;
  logic [CW-1:0]   nx_py;
  logic            at_last;

  // Integer pixel index to fixed point: zero-extend, then shift into the
  // integer field.
  function automatic logic [FP_WL-1:0] to_fp(input logic [CW-1:0] v);
    return {{(FP_WL-CW){1'b0}}, v} << FP_QW;
  endfunction

  assign at_last = (px == LAST_X) && (py == LAST_Y);

  // Raster advance: step x, or wrap x and step y at the end of a row.
  always_comb begin
    nx_px = px + ONE;
    nx_py = py;
    if (px == LAST_X) begin
      nx_px = '0;
      nx_py = py + ONE;
    end
  end

  // Gated with out_valid so the flag reads 0 out of reset even for a 1x1 image.
  assign out_last = out_valid && (out_px == LAST_X) && (out_py == LAST_Y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      px         <= '0;
      py         <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      rgu_start  <= 1'b0;
      rgu_x      <= '0;
      rgu_y      <= '0;
      out_valid  <= 1'b0;
      out_px     <= '0;
      out_py     <= '0;
      out_origin <= '0;
      out_dir    <= '0;
    end else begin
      rgu_start  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Also drops frame_busy one cycle after frame_done.
          frame_busy <= frame_start;
          if (frame_start) begin
            px        <= '0;
            py        <= '0;
            rgu_x     <= '0;
            rgu_y     <= '0;
            rgu_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (rgu_valid) begin
            out_origin <= rgu_origin;
            out_dir    <= rgu_dir;
            out_px     <= px;
            out_py     <= py;
            out_valid  <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (at_last) begin
              state <= S_DONE;
            end else begin
              // Coordinates for the next pixel are registered together with
              // the start strobe so they are stable for the whole RGU run.
              px        <= nx_px;
              py        <= nx_py;
              rgu_x     <= to_fp(nx_px);
              rgu_y     <= to_fp(nx_py);
              rgu_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          frame_done <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RT_SCAN_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
    end else if ((state == S_IDLE) && frame_start) begin
      perf_cycles <= '0;
    end else if (frame_busy) begin
      perf_cycles <= sat_inc(perf_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_rt_pixel_scanner.sv
module tb_rt_pixel_scanner;

  localparam int W        = 4;
  localparam int H        = 3;
  localparam int CW       = 16;
  localparam int FPW      = 32;
  localparam int QW       = 16;
  localparam int LAT      = 5;
  localparam int NPIX     = W * H;
  localparam int MIN_DONE = NPIX * (LAT + 2) + 2;
  localparam int BUDGET   = 3000;

  typedef struct packed {
    logic [FPW-1:0]   r;
    logic [3*FPW-1:0] d;
  } ray_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_start;
  logic               frame_busy;
  logic               frame_done;
  logic               rgu_start;
  logic [FPW-1:0]     rgu_x;
  logic [FPW-1:0]     rgu_y;
  logic               rgu_valid;
  logic [3*FPW-1:0]   rgu_origin;
  logic [3*FPW-1:0]   rgu_dir;
  logic               out_valid;
  logic               out_ready;
  logic [CW-1:0]      out_px;
  logic [CW-1:0]      out_py;
  logic               out_last;
  logic [3*FPW-1:0]   out_origin;
  logic [3*FPW-1:0]   out_dir;
`ifdef RT_SCAN_PERF_EN
  logic [31:0]        perf_cycles;
  int                 last_perf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rt_pixel_scanner #(
    .IMG_W(W), .IMG_H(H), .CW(CW), .FP_WL(FPW), .FP_QW(QW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .rgu_start(rgu_start),
    .rgu_x(rgu_x),
    .rgu_y(rgu_y),
    .rgu_valid(rgu_valid),
    .rgu_origin(rgu_origin),
    .rgu_dir(rgu_dir),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_px(out_px),
    .out_py(out_py),
    .out_last(out_last),
    .out_origin(out_origin),
    .out_dir(out_dir)
`ifdef RT_SCAN_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  // RGU stand-in: fixed latency LAT from sampled start to result. The
  // origin carries the coordinates it was started with plus a random word;
  // the random part of each ray is queued for the checker.
  logic [LAT-1:0] vpipe;
  logic [FPW-1:0]   x_pipe [LAT];
  logic [FPW-1:0]   y_pipe [LAT];
  logic [FPW-1:0]   r_pipe [LAT];
  logic [3*FPW-1:0] d_pipe [LAT];
  ray_t             new_ray;
  ray_t             exp_q [$];
  logic             spur;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe <= '0;
    end else begin
      vpipe <= {vpipe[LAT-2:0], rgu_start};
      if (rgu_start) begin
        new_ray.r = $urandom;
        new_ray.d = {$urandom, $urandom, $urandom};
        exp_q.push_back(new_ray);
      end
      x_pipe[0] <= rgu_x;
      y_pipe[0] <= rgu_y;
      r_pipe[0] <= new_ray.r;
      d_pipe[0] <= new_ray.d;
      for (int i = 1; i < LAT; i++) begin
        x_pipe[i] <= x_pipe[i-1];
        y_pipe[i] <= y_pipe[i-1];
        r_pipe[i] <= r_pipe[i-1];
        d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign rgu_valid  = vpipe[LAT-1] | spur;
  assign rgu_origin = spur ? {3*FPW{1'b1}} : {x_pipe[LAT-1], y_pipe[LAT-1], r_pipe[LAT-1]};
  assign rgu_dir    = spur ? {3*FPW{1'b1}} : d_pipe[LAT-1];

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b0; out_ready = 1'b1; spur = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_busy, frame_done, rgu_start, out_valid, out_last} !== 5'b0 ||
        rgu_x !== '0 || rgu_y !== '0 || out_px !== '0 || out_py !== '0 ||
        out_origin !== '0 || out_dir !== '0)
    begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b start=%b valid=%b last=%b x=%h y=%h px=%0d py=%0d, required all zero",
               frame_busy, frame_done, rgu_start, out_valid, out_last, rgu_x, rgu_y, out_px, out_py);
    end
`ifdef RT_SCAN_PERF_EN
    checks++;
    if (perf_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: got %0d required 0", perf_cycles);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One frame scenario. stall_pix/stall_len: hold out_ready low at that
  // raster index (with a spurious rgu_valid each stall cycle). rand_ready:
  // random backpressure. pulse_cyc: extra frame_start at that cycle.
  // abort_pix: assert reset while that ray is presented.
  task automatic test_frame(input string name, input int stall_pix, input int stall_len,
                            input bit rand_ready, input int pulse_cyc, input int abort_pix);
    int n, cyc, stalls, dones, done_cyc, st_used, exp_done;
    bit holding, acc_prev, exp_start, fin, bad;
    logic [CW-1:0]    h_px, h_py;
    logic [3*FPW-1:0] h_org, h_dir, e_org;
    logic [FPW-1:0]   ex_fp, ey_fp;
    ray_t             ray;
    n = 0; stalls = 0; dones = 0; done_cyc = -1; st_used = 0;
    holding = 0; acc_prev = 0; fin = 0;
    h_px = '0; h_py = '0; h_org = '0; h_dir = '0;
    out_ready = 1'b1; spur = 1'b0;
    frame_start = 1'b1;
    cyc = 0;
    while (!fin && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      frame_start = (cyc == pulse_cyc);
      exp_start = (cyc == 1) || (acc_prev && n < NPIX);
      acc_prev = 0;
      checks++;
      if (rgu_start !== exp_start) begin
        errors++;
        $display("FAIL %s rgu_start cyc %0d: got %b required %b", name, cyc, rgu_start, exp_start);
      end
      if (n < NPIX && frame_busy === 1'b1) begin
        ex_fp = 32'((n % W) << QW);
        ey_fp = 32'((n / W) << QW);
        checks++;
        if (rgu_x !== ex_fp || rgu_y !== ey_fp) begin
          errors++;
          $display("FAIL %s rgu_xy cyc %0d: got %h/%h required %h/%h", name, cyc, rgu_x, rgu_y, ex_fp, ey_fp);
        end
      end
      if (abort_pix >= 0 && out_valid === 1'b1 && n == abort_pix) begin
        checks++;
        if (out_px !== CW'(n % W) || out_py !== CW'(n / W)) begin
          errors++;
          $display("FAIL %s abort_point: got (%0d,%0d) required (%0d,%0d)", name, out_px, out_py, n % W, n / W);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({frame_busy, frame_done, rgu_start, out_valid, out_last} !== 5'b0 ||
            rgu_x !== '0 || rgu_y !== '0 || out_px !== '0 || out_py !== '0 ||
            out_origin !== '0 || out_dir !== '0) begin
          errors++;
          $display("FAIL %s async_reset: busy=%b valid=%b px=%0d py=%0d x=%h, required all zero",
                   name, frame_busy, out_valid, out_px, out_py, rgu_x);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0; spur = 1'b0; out_ready = 1'b1; frame_start = 1'b0;
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (frame_done !== 1'b0 || frame_busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL %s no_done_after_abort: got activity required none", name);
        end
        return;
      end
      if (out_valid === 1'b1) begin
        if (holding) begin
          checks++;
          if ({out_px, out_py, out_origin, out_dir} !== {h_px, h_py, h_org, h_dir}) begin
            errors++;
            $display("FAIL %s stall_stable cyc %0d: got (%0d,%0d) org %h required (%0d,%0d) org %h",
                     name, cyc, out_px, out_py, out_origin, h_px, h_py, h_org);
          end
        end
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        else            out_ready = !(n == stall_pix && st_used < stall_len);
        spur = !out_ready && !rand_ready;
        if (out_ready) begin
          ex_fp = 32'((n % W) << QW);
          ey_fp = 32'((n / W) << QW);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s extra_ray: got ray (%0d,%0d) required none", name, out_px, out_py);
          end else begin
            ray = exp_q.pop_front();
            e_org = {ex_fp, ey_fp, ray.r};
            if (out_px !== CW'(n % W) || out_py !== CW'(n / W) ||
                out_origin !== e_org || out_dir !== ray.d) begin
              errors++;
              $display("FAIL %s ray %0d: got (%0d,%0d) org %h dir %h required (%0d,%0d) org %h dir %h",
                       name, n, out_px, out_py, out_origin, out_dir, n % W, n / W, e_org, ray.d);
            end
          end
          checks++;
          if (out_last !== (n == NPIX - 1)) begin
            errors++;
            $display("FAIL %s out_last ray %0d: got %b required %b", name, n, out_last, (n == NPIX - 1));
          end
          n++;
          holding = 0;
          acc_prev = 1;
        end else begin
          stalls++;
          if (n == stall_pix) st_used++;
          holding = 1;
          h_px = out_px; h_py = out_py; h_org = out_origin; h_dir = out_dir;
        end
      end else begin
        out_ready = 1'b1;
        spur = 1'b0;
        holding = 0;
      end
      if (frame_done === 1'b1) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        checks++;
        if (frame_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_at_done: got %b required 1", name, frame_busy);
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        checks++;
        if (frame_busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_after_done: got %b required 0", name, frame_busy);
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) fin = 1;
    end
    spur = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    exp_done = MIN_DONE + stalls;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: got no frame_done in %0d cycles, required at cycle %0d", name, BUDGET, exp_done);
    end
    checks++;
    if (n != NPIX) begin
      errors++;
      $display("FAIL %s ray_count: got %0d required %0d", name, n, NPIX);
    end
    checks++;
    if (dones != 1 || done_cyc != exp_done) begin
      errors++;
      $display("FAIL %s frame_done: got %0d pulses at cycle %0d required 1 at cycle %0d", name, dones, done_cyc, exp_done);
    end
`ifdef RT_SCAN_PERF_EN
    checks++;
    if (perf_cycles !== 32'(exp_done)) begin
      errors++;
      $display("FAIL %s perf_cycles: got %0d required %0d", name, perf_cycles, exp_done);
    end
    last_perf = exp_done;
`endif
  endtask

  task automatic test_perf_hold();
`ifdef RT_SCAN_PERF_EN
    repeat (20) @(negedge clk);
    checks++;
    if (perf_cycles !== 32'(last_perf)) begin
      errors++;
      $display("FAIL perf_hold: got %0d required %0d", perf_cycles, last_perf);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame("full_frame",   -1, 0,  1'b0, -1, -1);
    test_frame("backpressure",  6, 10, 1'b0, -1, -1);
    test_perf_hold();
    test_frame("busy_ignore",  -1, 0,  1'b0, 30, -1);
    test_frame("random_ready", -1, 0,  1'b1, -1, -1);
    test_frame("abort",        -1, 0,  1'b0, -1,  5);
    test_frame("restart",      -1, 0,  1'b0, -1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
